// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz VGA timing constants and raster helpers shared by the
// sync generator and other pixel-rate blocks.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned DEF_CLK_DIV   = 4;
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam bit          DEF_SYNC_ACTIVE = 1'b0;

  localparam int unsigned DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  // True when lo <= v < hi.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Divides the system clock down to a one-clk pixel-rate enable.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign pix_tick = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (pix_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel counters, sync pulses, blanked colour pins and
// a once-per-frame strobe. Pins show coordinate N during pixel period N+1.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter bit          SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               red_ch,
  input  logic               green_ch,
  input  logic               blue_ch,
  output logic [COORD_W-1:0] x_crd,
  output logic [COORD_W-1:0] y_crd,
  output logic               video_on,
  output logic               frame_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               vga_r,
  output logic               vga_g,
  output logic               vga_b
);

  localparam int unsigned LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_BEGIN    = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_STOP     = HS_BEGIN + H_SYNC;
  localparam int unsigned VS_BEGIN    = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_STOP     = VS_BEGIN + V_SYNC;

  logic               pix_tick;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               line_end;
  logic               last_line;
  logic               hs_raw;
  logic               vs_raw;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick)
  );

  assign line_end  = (h_cnt == COORD_W'(LINE_TOTAL - 1));
  assign last_line = (v_cnt == COORD_W'(FRAME_LINES - 1));
  assign hs_raw    = in_window(h_cnt, COORD_W'(HS_BEGIN), COORD_W'(HS_STOP));
  assign vs_raw    = in_window(v_cnt, COORD_W'(VS_BEGIN), COORD_W'(VS_STOP));

  assign x_crd    = h_cnt;
  assign y_crd    = v_cnt;
  assign video_on = (h_cnt < COORD_W'(H_VISIBLE)) && (v_cnt < COORD_W'(V_VISIBLE));

  // Raster counters advance once per pixel period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= last_line ? '0 : v_cnt + COORD_W'(1);
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
    end
  end

  // Output stage: colour and sync captured together so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r <= 1'b0;
      vga_g <= 1'b0;
      vga_b <= 1'b0;
      hsync <= ~SYNC_ACTIVE;
      vsync <= ~SYNC_ACTIVE;
    end else if (pix_tick) begin
      vga_r <= red_ch   & video_on;
      vga_g <= green_ch & video_on;
      vga_b <= blue_ch  & video_on;
      hsync <= hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync <= vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_tick & line_end & last_line;
    end
  end

endmodule
